// File: rtl/vec_memory_bus_arb_if.sv
// Bundle of source-side and memory-side streams for the vector memory bus arbiter.
// Latency: none (wires only).
// Backpressure: valid/ready on every stream. slave = arbiter side, master = sources/memory/bench side.
// Ports: src_req_* (per-source requests), mem_req_* (request stream to memory),
//        mem_rsp_* (response stream from memory), src_rsp_* (responses routed to sources),
//        req_count (request FIFO occupancy), err_sticky (protocol violation seen).
interface vec_memory_bus_arb_if #(
   parameter int NUM_SOURCES = 4,
   parameter int VEC_W       = 256,
   parameter int ID_W        = 4,
   parameter int REQ_DEPTH   = 4
) ();
   localparam int PKT_W = 8 + ID_W + 2 * VEC_W;
   localparam int CNT_W = $clog2(REQ_DEPTH + 1);

   logic [NUM_SOURCES-1:0]       src_req_valid;
   logic [8*NUM_SOURCES-1:0]     src_req_type;
   logic [VEC_W*NUM_SOURCES-1:0] src_req_addr;
   logic [VEC_W*NUM_SOURCES-1:0] src_req_payload;
   logic [NUM_SOURCES-1:0]       src_req_ready;

   logic                         mem_req_valid;
   logic [PKT_W-1:0]             mem_req_pkt;
   logic                         mem_req_ready;

   logic                         mem_rsp_valid;
   logic [PKT_W-1:0]             mem_rsp_pkt;
   logic                         mem_rsp_ready;

   logic [NUM_SOURCES-1:0]       src_rsp_valid;
   logic [PKT_W-1:0]             src_rsp_pkt;
   logic [NUM_SOURCES-1:0]       src_rsp_ready;

   logic [CNT_W-1:0]             req_count;
   logic                         err_sticky;

   modport slave (
      input  src_req_valid, src_req_type, src_req_addr, src_req_payload,
      output src_req_ready,
      output mem_req_valid, mem_req_pkt,
      input  mem_req_ready,
      input  mem_rsp_valid, mem_rsp_pkt,
      output mem_rsp_ready,
      output src_rsp_valid, src_rsp_pkt,
      input  src_rsp_ready,
      output req_count, err_sticky
   );

   modport master (
      output src_req_valid, src_req_type, src_req_addr, src_req_payload,
      input  src_req_ready,
      input  mem_req_valid, mem_req_pkt,
      output mem_req_ready,
      output mem_rsp_valid, mem_rsp_pkt,
      input  mem_rsp_ready,
      input  src_rsp_valid, src_rsp_pkt,
      output src_rsp_ready,
      input  req_count, err_sticky
   );
endinterface

// File: rtl/vec_memory_bus_arb.sv
// Round-robin arbiter from NUM_SOURCES vector units onto one memory request stream,
// with a response FIFO that routes memory responses back to the owning source.
// Latency: 1 cycle accept-to-visible on both FIFOs (first-word-fall-through, no bypass).
// Backpressure: src_req_ready drops while the request FIFO is full; mem_rsp_ready drops
//    while the response FIFO is full; a stalled response head blocks later responses.
// Ports: clk, rst_n (async active-low); bus (slave modport of vec_memory_bus_arb_if).

// Generic power-of-two FIFO; head is readable whenever o_count != 0.
// Latency: push visible at o_dat one cycle later. Backpressure: caller gates push/pop.
// Ports: i_push/i_dat write side, i_pop read side, o_dat head, o_count occupancy.
module vec_mba_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_push,
   input  logic [W-1:0]               i_dat,
   input  logic                       i_pop,
   output logic [W-1:0]               o_dat,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_cnt;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
      end
   end

   // Storage needs no reset: the top masks the head while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_dat;
   end

   assign o_dat   = r_mem[r_rd_ptr];
   assign o_count = r_cnt;
endmodule

module vec_memory_bus_arb #(
   parameter int NUM_SOURCES = 4,
   parameter int VEC_W       = 256,
   parameter int ID_W        = 4,
   parameter int REQ_DEPTH   = 4,
   parameter int RSP_DEPTH   = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   vec_memory_bus_arb_if.slave bus
);
   localparam int PKT_W = 8 + ID_W + 2 * VEC_W;
   localparam int PW    = $clog2(NUM_SOURCES);
   localparam int RQ_CW = $clog2(REQ_DEPTH + 1);
   localparam int RS_CW = $clog2(RSP_DEPTH + 1);

   // ---------------- request arbitration ----------------
   logic [PW-1:0]          r_rr_ptr;
   logic                   r_err;
   logic                   w_gnt_vld;
   logic [PW-1:0]          w_gnt_idx;
   logic [NUM_SOURCES-1:0] w_gnt_oh;
   logic [7:0]             w_gnt_type;
   logic [VEC_W-1:0]       w_gnt_addr;
   logic [VEC_W-1:0]       w_gnt_pay;
   logic [VEC_W-1:0]       w_req_pay;
   logic [PKT_W-1:0]       w_req_dat;
   logic [PKT_W-1:0]       w_req_head;
   logic [RQ_CW-1:0]       w_req_cnt;
   logic                   w_req_full;
   logic                   w_req_empty;
   logic                   w_req_acc;
   logic                   w_req_type_ok;
   logic                   w_req_push;
   logic                   w_req_pop;
   logic                   w_req_drop;

   // Two passes give the wrap-around search: first indices at/after rr_ptr, then below it.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      for (int j = 0; j < NUM_SOURCES; j++) begin
         if (!w_gnt_vld && bus.src_req_valid[j] && (PW'(j) >= r_rr_ptr)) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = PW'(j);
         end
      end
      for (int j = 0; j < NUM_SOURCES; j++) begin
         if (!w_gnt_vld && bus.src_req_valid[j]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = PW'(j);
         end
      end
   end

   always_comb begin
      w_gnt_oh   = '0;
      w_gnt_type = '0;
      w_gnt_addr = '0;
      w_gnt_pay  = '0;
      for (int j = 0; j < NUM_SOURCES; j++) begin
         if (w_gnt_idx == PW'(j)) begin
            w_gnt_oh[j] = w_gnt_vld;
            w_gnt_type  = bus.src_req_type[8*j +: 8];
            w_gnt_addr  = bus.src_req_addr[VEC_W*j +: VEC_W];
            w_gnt_pay   = bus.src_req_payload[VEC_W*j +: VEC_W];
         end
      end
   end

   assign w_req_full    = (w_req_cnt == RQ_CW'(REQ_DEPTH));
   assign w_req_empty   = (w_req_cnt == '0);
   // Full blocks acceptance even when the memory side pops the same cycle.
   assign bus.src_req_ready = (rst_n && !w_req_full) ? w_gnt_oh : '0;
   assign w_req_acc     = |(bus.src_req_valid & bus.src_req_ready);
   assign w_req_type_ok = (w_gnt_type == 8'd0) || (w_gnt_type == 8'd1);
   assign w_req_push    = w_req_acc && w_req_type_ok;
   assign w_req_drop    = w_req_acc && !w_req_type_ok;
   assign w_req_pay     = (w_gnt_type == 8'd0) ? '0 : w_gnt_pay;
   assign w_req_dat     = {w_gnt_type, ID_W'(w_gnt_idx), w_gnt_addr, w_req_pay};
   assign w_req_pop     = !w_req_empty && bus.mem_req_ready;

   // Dropped (bad-type) requests still count as accepted, so the pointer moves on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr <= '0;
      end else if (w_req_acc) begin
         r_rr_ptr <= (w_gnt_idx == PW'(NUM_SOURCES - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
   end

   vec_mba_fifo #(.W(PKT_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_req_push),
      .i_dat   (w_req_dat),
      .i_pop   (w_req_pop),
      .o_dat   (w_req_head),
      .o_count (w_req_cnt)
   );

   assign bus.mem_req_valid = !w_req_empty;
   assign bus.mem_req_pkt   = w_req_empty ? '0 : w_req_head;
   assign bus.req_count     = w_req_cnt;

   // ---------------- response routing ----------------
   logic [PKT_W-1:0]       w_rsp_head;
   logic [RS_CW-1:0]       w_rsp_cnt;
   logic                   w_rsp_full;
   logic                   w_rsp_empty;
   logic                   w_rsp_push;
   logic                   w_rsp_pop;
   logic                   w_rsp_drop;
   logic [7:0]             w_rsp_type;
   logic [ID_W-1:0]        w_rsp_src;
   logic                   w_rsp_bad;
   logic [NUM_SOURCES-1:0] w_rsp_oh;
   logic                   w_rsp_sel_rdy;

   assign w_rsp_full  = (w_rsp_cnt == RS_CW'(RSP_DEPTH));
   assign w_rsp_empty = (w_rsp_cnt == '0);
   assign bus.mem_rsp_ready = rst_n && !w_rsp_full;
   assign w_rsp_push  = bus.mem_rsp_valid && bus.mem_rsp_ready;

   assign w_rsp_type = w_rsp_head[PKT_W-1 -: 8];
   assign w_rsp_src  = w_rsp_head[PKT_W-9 -: ID_W];
   // Compare as int so NUM_SOURCES == 2**ID_W does not truncate the bound.
   assign w_rsp_bad  = !((w_rsp_type == 8'd2) || (w_rsp_type == 8'd3)) ||
                       (int'(w_rsp_src) >= NUM_SOURCES);

   // Only the head's own source's ready matters; the others are ignored.
   always_comb begin
      w_rsp_oh      = '0;
      w_rsp_sel_rdy = 1'b0;
      for (int j = 0; j < NUM_SOURCES; j++) begin
         if (int'(w_rsp_src) == j) begin
            w_rsp_oh[j]   = 1'b1;
            w_rsp_sel_rdy = bus.src_rsp_ready[j];
         end
      end
   end

   // A malformed head is discarded without being offered to any source.
   assign w_rsp_pop  = !w_rsp_empty && (w_rsp_bad || w_rsp_sel_rdy);
   assign w_rsp_drop = !w_rsp_empty && w_rsp_bad;

   vec_mba_fifo #(.W(PKT_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_rsp_push),
      .i_dat   (bus.mem_rsp_pkt),
      .i_pop   (w_rsp_pop),
      .o_dat   (w_rsp_head),
      .o_count (w_rsp_cnt)
   );

   assign bus.src_rsp_valid = (!w_rsp_empty && !w_rsp_bad) ? w_rsp_oh : '0;
   assign bus.src_rsp_pkt   = w_rsp_empty ? '0 : w_rsp_head;

   // ---------------- sticky error ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (w_req_drop || w_rsp_drop) begin
         r_err <= 1'b1;
      end
   end

   assign bus.err_sticky = r_err;
endmodule

// File: tb/tb_vec_memory_bus_arb.sv
// Directed bench for vec_memory_bus_arb (4 sources, 32-bit vectors, depth-4 FIFOs).
// Latency: n/a. Backpressure: driven directly by the stimulus sequence.
// Ports: none; instantiates the bus interface and the arbiter.
module tb_vec_memory_bus_arb;
   localparam int NS    = 4;
   localparam int VW    = 32;
   localparam int IW    = 4;
   localparam int PKT_W = 8 + IW + 2 * VW;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   vec_memory_bus_arb_if #(.NUM_SOURCES(NS), .VEC_W(VW), .ID_W(IW), .REQ_DEPTH(4)) bus ();

   vec_memory_bus_arb #(
      .NUM_SOURCES (NS),
      .VEC_W       (VW),
      .ID_W        (IW),
      .REQ_DEPTH   (4),
      .RSP_DEPTH   (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [PKT_W-1:0] mk(input logic [7:0] t, input logic [IW-1:0] s,
                                           input logic [VW-1:0] a, input logic [VW-1:0] p);
      return {t, s, a, p};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int s, input logic [7:0] t, input logic [VW-1:0] a,
                          input logic [VW-1:0] p);
      bus.src_req_type[8*s +: 8]     = t;
      bus.src_req_addr[VW*s +: VW]   = a;
      bus.src_req_payload[VW*s +: VW] = p;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus.src_req_valid   = 4'hF;
      bus.src_req_type    = '0;
      bus.src_req_addr    = '0;
      bus.src_req_payload = '0;
      bus.mem_req_ready   = 1'b1;
      bus.mem_rsp_valid   = 1'b0;
      bus.mem_rsp_pkt     = '0;
      bus.src_rsp_ready   = 4'hF;
      #12;
      // Reset state
      chk("rst_src_req_ready", bus.src_req_ready, 0);
      chk("rst_mem_req_valid", bus.mem_req_valid, 0);
      chk("rst_req_count", bus.req_count, 0);
      chk("rst_mem_rsp_ready", bus.mem_rsp_ready, 0);
      chk("rst_src_rsp_valid", bus.src_rsp_valid, 0);
      chk("rst_err", bus.err_sticky, 0);
      chk("rst_mem_req_pkt", bus.mem_req_pkt, 0);
      chk("rst_src_rsp_pkt", bus.src_rsp_pkt, 0);

      // Round-robin with all sources valid and memory always ready
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < NS; i++) set_src(i, 8'd1, 32'h100 + i, 32'hA0 + i);
      bus.src_rsp_ready = 4'h0;
      #1;
      chk("rr_first_ready", bus.src_req_ready, 4'b0001);
      chk("rr_no_bypass", bus.mem_req_valid, 0);
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk("rr_seq_pkt", bus.mem_req_pkt,
             mk(8'd1, IW'((k - 1) % 4), 32'h100 + (k - 1) % 4, 32'hA0 + (k - 1) % 4));
         chk("rr_seq_count", bus.req_count, 1);
      end
      bus.src_req_valid = 4'b0000;
      tick();
      chk("rr_drained_valid", bus.mem_req_valid, 0);
      chk("rr_drained_count", bus.req_count, 0);

      // Request FIFO fill with memory stalled
      bus.mem_req_ready = 1'b0;
      bus.src_req_valid = 4'b0010;
      for (int j = 0; j < 4; j++) begin
         set_src(1, 8'd1, 32'h200, 32'h50 + j);
         #1;
         chk("fill_ready", bus.src_req_ready, 4'b0010);
         tick();
      end
      set_src(1, 8'd1, 32'h200, 32'h54);
      #1;
      chk("full_ready", bus.src_req_ready, 4'b0000);
      chk("full_count", bus.req_count, 4);
      chk("full_head", bus.mem_req_pkt, mk(8'd1, 4'd1, 32'h200, 32'h50));
      bus.mem_req_ready = 1'b1;
      #1;
      chk("full_pop_ready", bus.src_req_ready, 4'b0000);
      tick();
      bus.mem_req_ready = 1'b0;
      #1;
      chk("after_pop_count", bus.req_count, 3);
      chk("after_pop_ready", bus.src_req_ready, 4'b0010);
      tick();
      chk("fifth_accepted", bus.req_count, 4);
      bus.src_req_valid = 4'b0000;
      bus.mem_req_ready = 1'b1;
      for (int j = 1; j <= 4; j++) begin
         chk("drain_order", bus.mem_req_pkt, mk(8'd1, 4'd1, 32'h200, 32'h50 + j));
         tick();
      end
      chk("drain_empty", bus.mem_req_valid, 0);

      // Read request payload forced to zero
      bus.mem_req_ready = 1'b0;
      set_src(2, 8'd0, 32'h40, 32'hFFFF_FFFF);
      bus.src_req_valid = 4'b0100;
      #1;
      chk("read_ready", bus.src_req_ready, 4'b0100);
      tick();
      bus.src_req_valid = 4'b0000;
      chk("read_pkt", bus.mem_req_pkt, mk(8'd0, 4'd2, 32'h40, 32'h0));
      bus.mem_req_ready = 1'b1;
      tick();
      chk("read_popped", bus.mem_req_valid, 0);
      bus.mem_req_ready = 1'b0;

      // Head-of-line response routing
      bus.src_rsp_ready = 4'b0001;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_pkt   = mk(8'd2, 4'd3, 32'h70, 32'hD3);
      #1;
      chk("rsp_ready", bus.mem_rsp_ready, 1);
      chk("rsp_no_bypass", bus.src_rsp_valid, 0);
      tick();
      bus.mem_rsp_pkt = mk(8'd3, 4'd0, 32'h80, 32'hD0);
      #1;
      chk("rsp3_valid", bus.src_rsp_valid, 4'b1000);
      tick();
      bus.mem_rsp_valid = 1'b0;
      #1;
      chk("hol_hold_1", bus.src_rsp_valid, 4'b1000);
      tick();
      chk("hol_hold_2", bus.src_rsp_valid, 4'b1000);
      chk("hol_pkt", bus.src_rsp_pkt, mk(8'd2, 4'd3, 32'h70, 32'hD3));
      bus.src_rsp_ready = 4'b1001;
      tick();
      chk("rsp0_valid", bus.src_rsp_valid, 4'b0001);
      chk("rsp0_pkt", bus.src_rsp_pkt, mk(8'd3, 4'd0, 32'h80, 32'hD0));
      tick();
      chk("rsp_empty", bus.src_rsp_valid, 4'b0000);
      chk("rsp_empty_pkt", bus.src_rsp_pkt, 0);

      // Response FIFO full
      bus.src_rsp_ready = 4'b0000;
      bus.mem_rsp_valid = 1'b1;
      for (int j = 0; j < 4; j++) begin
         bus.mem_rsp_pkt = mk(8'd3, 4'd2, 32'h90, j);
         #1;
         chk("rsp_fill_ready", bus.mem_rsp_ready, 1);
         tick();
      end
      bus.mem_rsp_pkt   = mk(8'd3, 4'd2, 32'h90, 32'h4);
      bus.src_rsp_ready = 4'b0100;
      #1;
      chk("rsp_full_ready", bus.mem_rsp_ready, 0);
      chk("rsp_full_valid", bus.src_rsp_valid, 4'b0100);
      chk("rsp_full_head", bus.src_rsp_pkt, mk(8'd3, 4'd2, 32'h90, 32'h0));
      tick();
      bus.mem_rsp_valid = 1'b0;
      for (int j = 1; j <= 3; j++) begin
         chk("rsp_drain", bus.src_rsp_pkt, mk(8'd3, 4'd2, 32'h90, j));
         tick();
      end
      chk("rsp_drained", bus.src_rsp_valid, 4'b0000);

      // Response to a nonexistent source
      bus.src_rsp_ready = 4'hF;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_pkt   = mk(8'd2, 4'd9, 32'h0, 32'h99);
      #1;
      tick();
      bus.mem_rsp_valid = 1'b0;
      #1;
      chk("bad_src_no_valid", bus.src_rsp_valid, 4'b0000);
      chk("err_before_drop", bus.err_sticky, 0);
      tick();
      chk("bad_src_err", bus.err_sticky, 1);
      chk("bad_src_dropped", bus.src_rsp_pkt, 0);
      tick();
      tick();
      chk("err_sticky_hold", bus.err_sticky, 1);

      // Asynchronous reset with queued requests
      bus.mem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) set_src(i, 8'd1, 32'h300 + i, 32'hC0 + i);
      bus.src_req_valid = 4'b0111;
      tick();
      tick();
      tick();
      bus.src_req_valid = 4'b0000;
      #1;
      chk("queued_count", bus.req_count, 3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_count", bus.req_count, 0);
      chk("async_rst_valid", bus.mem_req_valid, 0);
      chk("async_rst_err", bus.err_sticky, 0);
      chk("async_rst_pkt", bus.mem_req_pkt, 0);
      #2;
      rst_n = 1'b1;

      // Bad request type after reset: accepted on the first edge and dropped
      set_src(0, 8'd5, 32'h33, 32'h44);
      bus.src_req_valid = 4'b0011;
      #1;
      chk("post_rst_grant", bus.src_req_ready, 4'b0001);
      tick();
      chk("bad_type_err", bus.err_sticky, 1);
      chk("bad_type_dropped", bus.req_count, 0);
      chk("rr_after_drop", bus.src_req_ready, 4'b0010);
      tick();
      bus.src_req_valid = 4'b0000;
      chk("after_drop_count", bus.req_count, 1);
      chk("after_drop_pkt", bus.mem_req_pkt, mk(8'd1, 4'd1, 32'h301, 32'hC1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
